// File: rtl/op2_seq.sv
`default_nettype none
// ============================================================================
// Module   : op2_seq
// Purpose  : Sequential C = Y -/+ X*X using a shift-add multiplier, with
//            valid/ready handshakes on operands and result.
// Revision : 1.0
// ============================================================================
module op2_seq #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   X,
    input  logic [W-1:0]   Y,
    input  logic           H,
    input  logic           mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] C,
    output logic           neg
);

    localparam int             CW     = $clog2(W) + 1;
    localparam logic [CW-1:0]  C_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic            r_h;
    logic            r_mode;
    logic [2*W-1:0]  r_mcand;
    logic [2*W-1:0]  r_acc;
    logic [CW-1:0]   r_cnt;
    logic [2*W-1:0]  r_c;
    logic            r_neg;
    logic [2*W-1:0]  w_y_ext;

    assign w_y_ext = {{W{1'b0}}, r_y};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = H ? S_MUL : S_FIN;
            S_MUL:  if (r_cnt == C_LAST) w_next = S_FIN;
            S_FIN:  w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Multiplier is consumed LSB-first and the multiplicand pre-shifted,
    // which is the same as adding (X << cnt) when bit [cnt] of X is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_h     <= 1'b0;
            r_mode  <= 1'b0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_c     <= '0;
            r_neg   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= X;
                        r_y     <= Y;
                        r_h     <= H;
                        r_mode  <= mode;
                        r_mcand <= {{W{1'b0}}, X};
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_MUL: begin
                    if (r_x[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand <= r_mcand << 1;
                    r_x     <= r_x >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                end
                S_FIN: begin
                    if (!r_h) begin
                        r_c   <= '0;
                        r_neg <= 1'b0;
                    end else if (r_mode) begin
                        r_c   <= w_y_ext + r_acc;
                        r_neg <= 1'b0;
                    end else begin
                        r_c   <= w_y_ext - r_acc;
                        r_neg <= (w_y_ext < r_acc);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign C         = r_c;
    assign neg       = r_neg;

endmodule
`default_nettype wire

// File: doc/op2_seq.md
Name: op2_seq

Overview:
- Parametrised, sequential successor of the combinational square-and-subtract unit.
- Computes C = Y − X·X (subtract mode) or C = Y + X·X (add mode) on W-bit unsigned operands, using an iterative shift-add multiplier (one partial product per clock).
- Operands enter and results leave through valid/ready handshakes, so the block sits between a register-bank producer and a display/consumer stage.
- The H enable is kept: when H=0 the result is forced to zero through a short path.

Parameters:
- W, 4, operand width in bits (W ≥ 2); result width is 2W.
- CW, $clog2(W)+1, iteration-counter width (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- X  input  W  unsigned operand to be squared
- Y  input  W  unsigned addend/minuend
- H  input  1  enable; 0 forces result 0
- mode  input  1  0 = Y − X·X, 1 = Y + X·X
- out_valid  output  1  C/neg valid
- out_ready  input  1  consumer accepts result
- C  output  2W  result, modulo 2^(2W)
- neg  output  1  subtract-mode borrow (Y < X·X)

Behaviour:
- Reset:
  - Asynchronous on rst_n low, regardless of clk.
  - State ← IDLE; in_ready=1 after release; out_valid=0; C=0; neg=0; internal accumulator, multiplicand, multiplier and counter all cleared.
  - Reset asserted mid-operation aborts the computation; no result is ever presented for that operand set.
- States: IDLE, MUL, FIN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the block latches X, Y, H and mode, and clears the accumulator.
  - If H=1, next state is MUL with counter=0.
  - If H=0, next state is FIN directly.
- MUL:
  - Each edge examines multiplier bit [counter] of X.
  - If that bit is 1, the accumulator (2W bits) adds the multiplicand shifted left by counter.
  - Counter increments on every MUL edge.
  - After W edges, counter reaches W and next state is FIN.
  - in_ready=0.
- FIN:
  - One edge computes the result.
  - H=1, mode=0: C ← (Y zero-extended) − acc, taken mod 2^(2W); neg ← (Y < acc).
  - H=1, mode=1: C ← Y + acc; neg ← 0. This sum cannot overflow: the maximum is 2^(2W) − 2^W.
  - H=0: C ← 0 and neg ← 0, regardless of mode.
  - Next state is DONE.
- DONE:
  - out_valid=1.
  - C and neg are held stable while out_ready=0.
  - On an edge with out_ready=1, next state is IDLE; out_valid falls and in_ready rises on that edge.
  - C and neg keep their last values after leaving DONE (registered, not cleared).
- Latency, counted in rising edges from the accept edge to the first edge at which out_valid=1:
  - W+2 when H=1 (e.g. 6 for W=4).
  - 2 when H=0.
- Throughput:
  - One operation in flight.
  - No operand is accepted while MUL, FIN or DONE is active.
  - in_valid held high in those states is ignored, not queued.
- Simultaneous out_ready and in_valid in DONE:
  - The result is retired.
  - The new operands are not accepted on that edge; they are accepted no earlier than the following edge, in IDLE.
- Operands X, Y, H and mode may change freely after the accept edge; the latched copies are used.
- X=0 or Y=0 need no special case; the arithmetic covers them.
- No X/Z propagation: all state registers have a defined reset value.

Test Plan:
- W=4, H=1, mode=0, X=3, Y=10, out_ready=1 → out_valid rises 6 edges after accept; C=8'h01, neg=0; in_ready returns one edge later.
- W=4, H=1, mode=0, X=4, Y=5 → C=8'hF5 (−11 mod 256), neg=1. Then mode=1, X=15, Y=15 → C=8'hF0 (240), neg=0.
- W=4, H=0, X=7, Y=9, mode=1 → out_valid after 2 edges, C=8'h00, neg=0. Pulsing in_valid during MUL of a prior op → ignored, no second result.
- Backpressure: complete X=2, Y=1, mode=0 with out_ready=0 for 10 cycles → out_valid stays 1, C=8'hFD, neg=1 constant. Raise out_ready → exactly one retirement, then IDLE.
- Reset mid-MUL: accept X=5, Y=3, pull rst_n low between clock edges on cycle 2 → outputs clear immediately (C=0, out_valid=0, in_ready=1 after release). The next op X=1, Y=1, mode=0 yields C=0, neg=0 with normal latency.
- W=8 instance: X=255, Y=0, mode=0 → C=16'h01FF, neg=1, latency 10 edges. X=255, Y=255, mode=1 → C=16'hFF00, neg=0.
